phy_rx: RTL and testbench

PHY_RX -- requirements
Module: phy_rx

---
 rtl/phy_rx_pkg.sv | 21 ++
 rtl/phy_rx_lane.sv | 124 ++++++++++++
 rtl/phy_rx.sv | 91 +++++++++
 tb/tb_phy_rx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/phy_rx_pkg.sv
//------------------------------------------------------------------------------
// Module   : phy_rx_pkg
// Purpose  : Shared PHY defines: comma byte, sync threshold, lane state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package phy_rx_pkg;

    localparam logic [7:0] c_COM_BYTE_DEFAULT   = 8'hBC;
    localparam int         c_SYNC_COUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_SYNC   = 2'd2
    } lane_state_e;

endpackage

`default_nettype wire

// File: rtl/phy_rx_lane.sv
//------------------------------------------------------------------------------
// Module   : phy_rx_lane
// Purpose  : One serial lane: comma alignment, byte framing, half-word assembly.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module phy_rx_lane
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COM_BYTE   = c_COM_BYTE_DEFAULT,
    parameter int         SYNC_COUNT = c_SYNC_COUNT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_serial,
    input  logic        i_accept,
    input  logic        i_flush,
    output logic        o_sync,
    output logic        o_data_strobe,
    output logic        o_half_done,
    output logic [15:0] o_half
);

    localparam int c_CW = (SYNC_COUNT < 2) ? 1 : $clog2(SYNC_COUNT + 1);

    lane_state_e       r_state, w_state_nx;
    logic [7:0]        r_sr;
    logic [2:0]        r_bit_cnt, w_bit_cnt_nx;
    logic [c_CW-1:0]   r_com_cnt, w_com_cnt_nx;
    logic [7:0]        r_hi, w_hi_nx;
    logic              r_have_hi, w_have_hi_nx;

    logic [7:0]        w_sr;
    logic              w_is_com;
    logic              w_boundary;
    logic [c_CW-1:0]   w_cnt_inc;

    assign w_sr       = {r_sr[6:0], i_serial};
    assign w_is_com   = (w_sr == COM_BYTE);
    assign w_boundary = (r_state != ST_SEARCH) && (r_bit_cnt == 3'd7);
    assign w_cnt_inc  = r_com_cnt + 1'b1;

    assign o_sync        = (r_state == ST_SYNC);
    assign o_data_strobe = o_sync && w_boundary && !w_is_com;
    assign o_half_done   = o_data_strobe && i_accept && r_have_hi;
    assign o_half        = {r_hi, w_sr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_SEARCH;
            r_sr      <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_com_cnt <= '0;
            r_hi      <= 8'h00;
            r_have_hi <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_sr      <= w_sr;
            r_bit_cnt <= w_bit_cnt_nx;
            r_com_cnt <= w_com_cnt_nx;
            r_hi      <= w_hi_nx;
            r_have_hi <= w_have_hi_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt + 3'd1;
        w_com_cnt_nx = r_com_cnt;
        w_hi_nx      = r_hi;
        w_have_hi_nx = r_have_hi;

        case (r_state)
            ST_SEARCH: begin
                // The edge that completes a comma defines the byte boundary.
                w_bit_cnt_nx = 3'd0;
                if (w_is_com) begin
                    w_com_cnt_nx = c_CW'(1);
                    w_state_nx   = (SYNC_COUNT <= 1) ? ST_SYNC : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (w_boundary) begin
                    if (w_is_com) begin
                        w_com_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc == c_CW'(SYNC_COUNT))
                            w_state_nx = ST_SYNC;
                    end else begin
                        w_com_cnt_nx = '0;
                        w_bit_cnt_nx = 3'd0;
                        w_state_nx   = ST_SEARCH;
                    end
                end
            end
            ST_SYNC: begin
                if (o_data_strobe && i_accept) begin
                    if (r_have_hi) begin
                        w_have_hi_nx = 1'b0;
                    end else begin
                        w_hi_nx      = w_sr;
                        w_have_hi_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx   = ST_SEARCH;
                w_bit_cnt_nx = 3'd0;
                w_com_cnt_nx = '0;
            end
        endcase

        if (i_flush) begin
            w_state_nx   = ST_SEARCH;
            w_bit_cnt_nx = 3'd0;
            w_com_cnt_nx = '0;
            w_hi_nx      = 8'h00;
            w_have_hi_nx = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/phy_rx.sv
//------------------------------------------------------------------------------
// Module   : phy_rx
// Purpose  : Two-lane serial receiver reassembling 32-bit words with lane checks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module phy_rx
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COM_BYTE   = c_COM_BYTE_DEFAULT,
    parameter int         SYNC_COUNT = c_SYNC_COUNT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        serial_i0,
    input  logic        serial_i1,
    output logic [31:0] output_bus,
    output logic        valid_out,
    output logic        active_out,
    output logic        err_out
);

    logic        w_sync0, w_sync1;
    logic        w_strobe0, w_strobe1;
    logic        w_done0, w_done1;
    logic [15:0] w_half0, w_half1;
    logic        w_active;
    logic        w_mismatch;
    logic        w_word;

    logic [31:0] r_bus;
    logic        r_valid;
    logic        r_err;

    assign w_active = w_sync0 && w_sync1;
    // Lanes are expected to frame data in lockstep; any data/idle disagreement forces a resync.
    assign w_mismatch = w_active && (w_strobe0 != w_strobe1);
    assign w_word     = w_done0 && w_done1;

    phy_rx_lane #(
        .COM_BYTE   (COM_BYTE),
        .SYNC_COUNT (SYNC_COUNT)
    ) u_lane0 (
        .clk           (clk),
        .rst           (reset),
        .i_serial      (serial_i0),
        .i_accept      (w_active),
        .i_flush       (w_mismatch),
        .o_sync        (w_sync0),
        .o_data_strobe (w_strobe0),
        .o_half_done   (w_done0),
        .o_half        (w_half0)
    );

    phy_rx_lane #(
        .COM_BYTE   (COM_BYTE),
        .SYNC_COUNT (SYNC_COUNT)
    ) u_lane1 (
        .clk           (clk),
        .rst           (reset),
        .i_serial      (serial_i1),
        .i_accept      (w_active),
        .i_flush       (w_mismatch),
        .o_sync        (w_sync1),
        .o_data_strobe (w_strobe1),
        .o_half_done   (w_done1),
        .o_half        (w_half1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus   <= 32'h0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_word;
            r_err   <= w_mismatch;
            if (w_word)
                r_bus <= {w_half0, w_half1};
        end
    end

    assign output_bus = r_bus;
    assign valid_out  = r_valid;
    assign err_out    = r_err;
    assign active_out = w_active;

endmodule

`default_nettype wire

// File: tb/tb_phy_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_phy_rx
// Purpose  : Directed self-checking bench for phy_rx.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_phy_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        serial_i0 = 1'b0;
    logic        serial_i1 = 1'b0;
    logic [31:0] output_bus;
    logic        valid_out;
    logic        active_out;
    logic        err_out;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int v0;
    int e0;

    phy_rx dut (
        .clk        (clk),
        .reset      (reset),
        .serial_i0  (serial_i0),
        .serial_i1  (serial_i1),
        .output_bus (output_bus),
        .valid_out  (valid_out),
        .active_out (active_out),
        .err_out    (err_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_out === 1'b1) valid_cnt++;
        if (err_out === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic b0, input logic b1);
        serial_i0 = b0;
        serial_i1 = b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(a[i], b[i]);
    endtask

    task automatic sync4();
        for (int k = 0; k < 4; k++) send(8'hBC, 8'hBC);
    endtask

    initial begin
        // Reset applied with no clock edge yet.
        #1 reset = 1'b1;
        #1;
        chk("rst_bus",    output_bus, 32'h0);
        chk("rst_valid",  {31'd0, valid_out},  32'd0);
        chk("rst_active", {31'd0, active_out}, 32'd0);
        chk("rst_err",    {31'd0, err_out},    32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Alignment: active rises exactly on the 32nd bit.
        for (int k = 0; k < 3; k++) send(8'hBC, 8'hBC);
        for (int i = 7; i >= 1; i--) tick(1'b0 ^ ((8'hBC >> i) & 1), 1'b0 ^ ((8'hBC >> i) & 1));
        chk("active_bit31", {31'd0, active_out}, 32'd0);
        tick(1'b0, 1'b0);
        chk("active_bit32", {31'd0, active_out}, 32'd1);

        // First word.
        v0 = valid_cnt;
        send(8'h12, 8'h56);
        chk("valid_half", {31'd0, valid_out}, 32'd0);
        send(8'h34, 8'h78);
        chk("word1_bus",   output_bus, 32'h12345678);
        chk("word1_valid", {31'd0, valid_out}, 32'd1);
        send(8'hBC, 8'hBC);
        chk("word1_pulse", valid_cnt - v0, 32'd1);
        chk("word1_hold",  output_bus, 32'h12345678);

        // Idle between the two bytes of a half-word.
        send(8'hAB, 8'hEF);
        send(8'hBC, 8'hBC);
        send(8'hCD, 8'h01);
        chk("idle_mid_bus", output_bus, 32'hABCDEF01);
        chk("idle_mid_valid", {31'd0, valid_out}, 32'd1);

        // Lane mismatch.
        send(8'hBC, 8'hBC);
        v0 = valid_cnt;
        e0 = err_cnt;
        send(8'hAA, 8'hBC);
        chk("mm_err",    {31'd0, err_out},    32'd1);
        chk("mm_active", {31'd0, active_out}, 32'd0);
        chk("mm_valid",  {31'd0, valid_out},  32'd0);

        // Garbage bits then resync.
        tick(1'b1, 1'b1);
        chk("mm_err_pulse", err_cnt - e0, 32'd1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        chk("mm_no_valid", valid_cnt - v0, 32'd0);
        sync4();
        chk("garbage_active", {31'd0, active_out}, 32'd1);
        send(8'hDE, 8'hBE);
        send(8'hAD, 8'hEF);
        chk("garbage_bus", output_bus, 32'hDEADBEEF);
        chk("garbage_valid", {31'd0, valid_out}, 32'd1);

        // Reset after the first data byte of a word, asserted between edges.
        send(8'h11, 8'h22);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_bus",    output_bus, 32'h0);
        chk("mid_rst_active", {31'd0, active_out}, 32'd0);
        chk("mid_rst_valid",  {31'd0, valid_out},  32'd0);
        serial_i0 = 1'b0;
        serial_i1 = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Failed alignment: three commas then a non-comma.
        v0 = valid_cnt;
        for (int k = 0; k < 3; k++) send(8'hBC, 8'hBC);
        send(8'h55, 8'h55);
        chk("bad_align_active", {31'd0, active_out}, 32'd0);
        send(8'h33, 8'h55);
        chk("bad_align_novalid", valid_cnt - v0, 32'd0);
        chk("bad_align_bus", output_bus, 32'h0);
        sync4();
        chk("resync_active", {31'd0, active_out}, 32'd1);

        // First word after reset must not contain any stale half.
        send(8'h33, 8'h55);
        chk("post_rst_half", {31'd0, valid_out}, 32'd0);
        send(8'h44, 8'h66);
        chk("post_rst_bus", output_bus, 32'h33445566);
        send(8'hBC, 8'hBC);
        chk("post_rst_pulses", valid_cnt - v0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
